// File: rtl/dram_cache_pkg.sv
// Shared DRAM-cache definitions used by the request dispatcher and the ROB.
//   TID_WIDTH : width of every transaction ID
//   tid_t     : transaction ID type
//   tid_inc   : increment that wraps to 0 after count-1
package dram_cache_pkg;

    localparam int TID_WIDTH = 8;

    typedef logic [TID_WIDTH-1:0] tid_t;

    function automatic tid_t tid_inc(input tid_t tid, input int unsigned count);
        if (tid == tid_t'(count - 1)) begin
            return '0;
        end
        return tid + tid_t'(1);
    endfunction

endpackage

// File: rtl/dispatch_slot.sv
// One-entry valid/ready output register holding {tid, addr}.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   load             : write load_tid/load_addr into the slot this cycle
//   load_tid/addr    : data to capture
//   ready            : downstream consumes the slot when valid
//   valid, tid, addr : registered slot contents
module dispatch_slot
    import dram_cache_pkg::*;
#(
    parameter int ADDR_BIT_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  tid_t                     load_tid,
    input  logic [ADDR_BIT_SIZE-1:0] load_addr,
    input  logic                     ready,
    output logic                     valid,
    output tid_t                     tid,
    output logic [ADDR_BIT_SIZE-1:0] addr
);

    // A load wins over a drain so the slot can be emptied and refilled in
    // the same cycle. Data is only written on load, so a held entry is stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            tid   <= '0;
            addr  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tid   <= load_tid;
            addr  <= load_addr;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rob_tid_dispatcher.sv
// Stamps in-order requests with sequential tIDs, steers them to the hit or
// miss path through registered one-entry slots, caps issued-but-unretired
// tIDs, and checks the in-order retire stream from the ROB.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr/req_hit : upstream request handshake
//   hit_valid/hit_ready/hit_tid/hit_addr     : hit-path output slot
//   miss_valid/miss_ready/miss_tid/miss_addr : miss-path output slot
//   retire, retire_tid                : in-order retire stream from the ROB
//   outstanding                       : issued-minus-retired count
//   err                               : sticky retire protocol error
module rob_tid_dispatcher
    import dram_cache_pkg::*;
#(
    parameter int ADDR_BIT_SIZE   = 16,
    parameter int TID_COUNT       = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_BIT_SIZE-1:0] req_addr,
    input  logic                     req_hit,
    output logic                     hit_valid,
    input  logic                     hit_ready,
    output logic [7:0]               hit_tid,
    output logic [ADDR_BIT_SIZE-1:0] hit_addr,
    output logic                     miss_valid,
    input  logic                     miss_ready,
    output logic [7:0]               miss_tid,
    output logic [ADDR_BIT_SIZE-1:0] miss_addr,
    input  logic                     retire,
    input  logic [7:0]               retire_tid,
    output logic [7:0]               outstanding,
    output logic                     err
);

    generate
        if (TID_COUNT < 1 || TID_COUNT > 256) begin : g_bad_tid_count
            $error("rob_tid_dispatcher: TID_COUNT must be 1..256");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > TID_COUNT) begin : g_bad_max_out
            $error("rob_tid_dispatcher: MAX_OUTSTANDING must be 1..TID_COUNT");
        end
    endgenerate

    // One extra bit so a full 256-entry window does not wrap the count.
    localparam logic [8:0] MAX_CNT = 9'(MAX_OUTSTANDING);

    tid_t       issue_tid;
    tid_t       expect_tid;
    logic [8:0] cnt;

    logic credit;
    logic hit_free;
    logic miss_free;
    logic accept;
    logic retire_dec;
    logic retire_bad;

    assign credit    = (cnt < MAX_CNT);
    assign hit_free  = !hit_valid || hit_ready;
    assign miss_free = !miss_valid || miss_ready;

    // Stall is in-order: a request for a blocked slot holds req_ready low
    // rather than letting a later request overtake it.
    assign req_ready = credit && (req_hit ? hit_free : miss_free);
    assign accept    = req_valid && req_ready;

    // Any retire with credit outstanding retires one entry; a tID mismatch
    // still consumes it so expect_tid stays aligned with the ROB.
    assign retire_dec = retire && (cnt != 9'd0);
    assign retire_bad = retire && ((cnt == 9'd0) || (retire_tid != expect_tid));

    assign outstanding = cnt[8] ? 8'hff : cnt[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_tid  <= '0;
            expect_tid <= '0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                issue_tid <= tid_inc(issue_tid, TID_COUNT);
            end
            if (retire_dec) begin
                expect_tid <= tid_inc(expect_tid, TID_COUNT);
            end
            case ({accept, retire_dec})
                2'b10:   cnt <= cnt + 9'd1;
                2'b01:   cnt <= cnt - 9'd1;
                default: cnt <= cnt;
            endcase
            if (retire_bad) begin
                err <= 1'b1;
            end
        end
    end

    dispatch_slot #(
        .ADDR_BIT_SIZE(ADDR_BIT_SIZE)
    ) u_hit_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && req_hit),
        .load_tid  (issue_tid),
        .load_addr (req_addr),
        .ready     (hit_ready),
        .valid     (hit_valid),
        .tid       (hit_tid),
        .addr      (hit_addr)
    );

    dispatch_slot #(
        .ADDR_BIT_SIZE(ADDR_BIT_SIZE)
    ) u_miss_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && !req_hit),
        .load_tid  (issue_tid),
        .load_addr (req_addr),
        .ready     (miss_ready),
        .valid     (miss_valid),
        .tid       (miss_tid),
        .addr      (miss_addr)
    );

endmodule

// File: tb/tb_rob_tid_dispatcher.sv
// Scoreboard bench for rob_tid_dispatcher (TID_COUNT=8, MAX_OUTSTANDING=8).
module tb_rob_tid_dispatcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_hit = 1'b0;
    logic        hit_valid;
    logic        hit_ready = 1'b1;
    logic [7:0]  hit_tid;
    logic [15:0] hit_addr;
    logic        miss_valid;
    logic        miss_ready = 1'b1;
    logic [7:0]  miss_tid;
    logic [15:0] miss_addr;
    logic        retire = 1'b0;
    logic [7:0]  retire_tid = '0;
    logic [7:0]  outstanding;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] hit_q[$];
    logic [23:0] miss_q[$];

    rob_tid_dispatcher #(
        .ADDR_BIT_SIZE(16),
        .TID_COUNT(8),
        .MAX_OUTSTANDING(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_hit(req_hit),
        .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_tid(hit_tid), .hit_addr(hit_addr),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_tid(miss_tid), .miss_addr(miss_addr),
        .retire(retire), .retire_tid(retire_tid),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: a slot transfer happens at the next rising edge whenever
    // valid && ready is seen here.
    always @(negedge clk) begin
        if (!reset) begin
            if (hit_valid && hit_ready) begin
                logic [23:0] e;
                if (hit_q.size() == 0) begin
                    check("hit_unexpected", 1, 0);
                end else begin
                    e = hit_q.pop_front();
                    check("hit_tid", int'(hit_tid), int'(e[23:16]));
                    check("hit_addr", int'(hit_addr), int'(e[15:0]));
                end
            end
            if (miss_valid && miss_ready) begin
                logic [23:0] e;
                if (miss_q.size() == 0) begin
                    check("miss_unexpected", 1, 0);
                end else begin
                    e = miss_q.pop_front();
                    check("miss_tid", int'(miss_tid), int'(e[23:16]));
                    check("miss_addr", int'(miss_addr), int'(e[15:0]));
                end
            end
        end
    end

    // Present one request, wait (bounded) until it is accepted, and log the
    // hand-computed tID for the scoreboard. Returns at posedge+1.
    task automatic send_req(input logic hit, input logic [15:0] addr, input logic [7:0] exp_tid);
        int waited;
        req_valid = 1'b1;
        req_hit   = hit;
        req_addr  = addr;
        waited    = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("req_accept_timeout", 0, 1);
        end else if (hit) begin
            hit_q.push_back({exp_tid, addr});
        end else begin
            miss_q.push_back({exp_tid, addr});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_retire(input logic [7:0] tid);
        retire     = 1'b1;
        retire_tid = tid;
        @(posedge clk);
        #1;
        retire = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        retire    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hit_q.delete();
        miss_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_hit_valid", int'(hit_valid), 0);
        check("rst_miss_valid", int'(miss_valid), 0);
        check("rst_hit_tid", int'(hit_tid), 0);
        check("rst_miss_addr", int'(miss_addr), 0);
        check("rst_outstanding", int'(outstanding), 0);
        check("rst_err", int'(err), 0);
        check("rst_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;

        // Three back-to-back hits
        send_req(1'b1, 16'h0100, 8'd0);
        send_req(1'b1, 16'h0101, 8'd1);
        send_req(1'b1, 16'h0102, 8'd2);
        @(negedge clk);
        check("t1_outstanding", int'(outstanding), 3);
        @(posedge clk);
        #1;

        // Alternating hit/miss across the tID wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_req(i[0] == 1'b0, 16'h0200 + 16'(i), 8'(i));
        end
        for (int i = 0; i < 8; i++) begin
            do_retire(8'(i));
        end
        send_req(1'b1, 16'h0208, 8'd0);
        send_req(1'b0, 16'h0209, 8'd1);
        do_retire(8'd0);
        do_retire(8'd1);
        @(negedge clk);
        check("t2_outstanding", int'(outstanding), 0);
        check("t2_err", int'(err), 0);
        @(posedge clk);
        #1;

        // Blocked miss slot: second miss stalls, a hit goes through
        miss_ready = 1'b0;
        send_req(1'b0, 16'h0300, 8'd2);
        req_valid = 1'b1;
        req_hit   = 1'b0;
        req_addr  = 16'h0301;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t3_stall_ready", int'(req_ready), 0);
            check("t3_miss_tid_hold", int'(miss_tid), 2);
            check("t3_miss_addr_hold", int'(miss_addr), 16'h0300);
            check("t3_miss_valid_hold", int'(miss_valid), 1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        send_req(1'b1, 16'h0302, 8'd3);
        miss_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        do_retire(8'd2);
        do_retire(8'd3);
        @(negedge clk);
        check("t3_outstanding", int'(outstanding), 0);
        @(posedge clk);
        #1;

        // Credit limit
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_req(1'b1, 16'h0400 + 16'(i), 8'(i));
        end
        req_valid = 1'b1;
        req_hit   = 1'b1;
        req_addr  = 16'h0408;
        @(negedge clk);
        check("t4_full_ready", int'(req_ready), 0);
        check("t4_full_outstanding", int'(outstanding), 8);
        @(posedge clk);
        #1;
        retire     = 1'b1;
        retire_tid = 8'd0;
        @(negedge clk);
        check("t4_retire_cycle_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        retire = 1'b0;
        @(negedge clk);
        check("t4_after_retire_ready", int'(req_ready), 1);
        check("t4_after_retire_out", int'(outstanding), 7);
        // accept and retire land on the same edge
        hit_q.push_back({8'd0, 16'h0408});
        retire     = 1'b1;
        retire_tid = 8'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        retire    = 1'b0;
        @(negedge clk);
        check("t4_acc_ret_out", int'(outstanding), 7);
        check("t4_err", int'(err), 0);
        @(posedge clk);
        #1;
        for (int i = 2; i < 8; i++) begin
            do_retire(8'(i));
        end
        do_retire(8'd0);
        @(negedge clk);
        check("t4_drained_out", int'(outstanding), 0);
        check("t4_drained_err", int'(err), 0);
        @(posedge clk);
        #1;

        // Retire protocol errors
        do_reset();
        do_retire(8'd0);
        @(negedge clk);
        check("t5_empty_err", int'(err), 1);
        check("t5_empty_out", int'(outstanding), 0);
        @(posedge clk);
        #1;
        send_req(1'b1, 16'h0500, 8'd0);
        send_req(1'b1, 16'h0501, 8'd1);
        @(negedge clk);
        check("t5_out2", int'(outstanding), 2);
        @(posedge clk);
        #1;
        do_retire(8'd3);
        @(negedge clk);
        check("t5_mismatch_out", int'(outstanding), 1);
        check("t5_mismatch_err", int'(err), 1);
        @(posedge clk);
        #1;
        do_retire(8'd1);
        @(negedge clk);
        check("t5_resync_out", int'(outstanding), 0);
        check("t5_sticky_err", int'(err), 1);
        @(posedge clk);
        #1;

        // Reset mid-operation with both slots full and 5 outstanding
        do_reset();
        hit_ready  = 1'b1;
        miss_ready = 1'b0;
        send_req(1'b1, 16'h0600, 8'd0);
        send_req(1'b1, 16'h0601, 8'd1);
        send_req(1'b1, 16'h0602, 8'd2);
        send_req(1'b0, 16'h0603, 8'd3);
        hit_ready = 1'b0;
        send_req(1'b1, 16'h0604, 8'd4);
        @(negedge clk);
        check("t6_pre_hit_valid", int'(hit_valid), 1);
        check("t6_pre_miss_valid", int'(miss_valid), 1);
        check("t6_pre_out", int'(outstanding), 5);
        do_reset();
        @(negedge clk);
        check("t6_hit_valid", int'(hit_valid), 0);
        check("t6_miss_valid", int'(miss_valid), 0);
        check("t6_hit_tid", int'(hit_tid), 0);
        check("t6_miss_tid", int'(miss_tid), 0);
        check("t6_hit_addr", int'(hit_addr), 0);
        check("t6_miss_addr", int'(miss_addr), 0);
        check("t6_out", int'(outstanding), 0);
        check("t6_err", int'(err), 0);
        @(posedge clk);
        #1;
        hit_ready  = 1'b1;
        miss_ready = 1'b1;
        send_req(1'b1, 16'h0700, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("end_hit_q_empty", hit_q.size(), 0);
        check("end_miss_q_empty", miss_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
